// File: rtl/fwd_scoreboard.sv
// Operand forwarding selector with a pending-register scoreboard for long-latency ops.
// Produces per-source forwarded data plus a combined pipeline stall and a saturating stall counter.
module fwd_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NSRC   = 2,
  parameter int NSTAGE = 2,
  parameter int CNTW   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NSRC*5-1:0]      ex_rs,
  input  logic [NSRC-1:0]        ex_rs_valid,
  input  logic [NSTAGE*5-1:0]    stg_rd,
  input  logic [NSTAGE-1:0]      stg_wen,
  input  logic [NSTAGE-1:0]      stg_rdy,
  input  logic [NSTAGE*XLEN-1:0] stg_data,
  input  logic                   lop_issue,
  input  logic [4:0]             lop_rd,
  input  logic                   lop_done,
  input  logic [4:0]             lop_done_rd,
  input  logic                   flush,
  output logic [NSRC-1:0]        fwd_en,
  output logic [NSRC*XLEN-1:0]   fwd_data,
  output logic                   stall,
  output logic [CNTW-1:0]        stall_cnt
);

  logic [31:0]     pending;
  logic [31:0]     pending_nxt;
  logic [NSRC-1:0] hit;
  logic [NSRC-1:0] data_haz;
  logic [NSRC-1:0] sb_haz;
  logic            lop_haz;

  // Stages are scanned oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    fwd_en   = '0;
    fwd_data = '0;
    hit      = '0;
    data_haz = '0;
    sb_haz   = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int s = NSTAGE - 1; s >= 0; s--) begin
        if (ex_rs_valid[i] && stg_wen[s] && (ex_rs[5*i +: 5] != 5'd0) &&
            (ex_rs[5*i +: 5] == stg_rd[5*s +: 5])) begin
          hit[i]                  = 1'b1;
          fwd_en[i]               = stg_rdy[s];
          data_haz[i]             = !stg_rdy[s];
          fwd_data[XLEN*i +: XLEN] = stg_rdy[s] ? stg_data[XLEN*s +: XLEN] : '0;
        end
      end
      sb_haz[i] = ex_rs_valid[i] && pending[ex_rs[5*i +: 5]] && !hit[i];
    end
  end

  assign lop_haz = lop_issue && (|pending);
  assign stall   = (|data_haz) || (|sb_haz) || lop_haz;

  // A new issue is applied last so it survives a same-cycle done or flush.
  always_comb begin
    pending_nxt = flush ? 32'd0 : pending;
    if (lop_done) pending_nxt[lop_done_rd] = 1'b0;
    if (lop_issue && !stall && (lop_rd != 5'd0)) pending_nxt[lop_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= 32'd0;
      stall_cnt <= '0;
    end else begin
      pending <= pending_nxt;
      if (stall && (stall_cnt != {CNTW{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: stimulus pushes expected outputs into a queue,
// a negedge monitor pops and compares them against the DUT.
module tb_fwd_scoreboard;
  localparam int XLEN = 32, NSRC = 2, NSTAGE = 2, CNTW = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NSRC*5-1:0]      ex_rs;
  logic [NSRC-1:0]        ex_rs_valid;
  logic [NSTAGE*5-1:0]    stg_rd;
  logic [NSTAGE-1:0]      stg_wen, stg_rdy;
  logic [NSTAGE*XLEN-1:0] stg_data;
  logic                   lop_issue, lop_done, flush;
  logic [4:0]             lop_rd, lop_done_rd;
  logic [NSRC-1:0]        fwd_en;
  logic [NSRC*XLEN-1:0]   fwd_data;
  logic                   stall;
  logic [CNTW-1:0]        stall_cnt;

  fwd_scoreboard #(.XLEN(XLEN), .NSRC(NSRC), .NSTAGE(NSTAGE), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_rs(ex_rs), .ex_rs_valid(ex_rs_valid),
    .stg_rd(stg_rd), .stg_wen(stg_wen), .stg_rdy(stg_rdy), .stg_data(stg_data),
    .lop_issue(lop_issue), .lop_rd(lop_rd), .lop_done(lop_done), .lop_done_rd(lop_done_rd),
    .flush(flush), .fwd_en(fwd_en), .fwd_data(fwd_data), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         nm;
    logic [1:0]    en;
    logic [63:0]   d;
    logic          st;
    logic [CNTW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_push = 0;
  logic [CNTW-1:0] exp_cnt = '0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (fwd_en !== e.en || fwd_data !== e.d || stall !== e.st || stall_cnt !== e.cnt) begin
        n_bad++;
        $display("FAIL %s: got en=%b data=%h stall=%b cnt=%0d, want en=%b data=%h stall=%b cnt=%0d",
                 e.nm, fwd_en, fwd_data, stall, stall_cnt, e.en, e.d, e.st, e.cnt);
      end
    end
  end

  // Queue the expectation, let the monitor sample it, then advance to just after the next edge.
  task automatic chk(input string nm, input logic [1:0] en, input logic [63:0] d, input logic st);
    exp_t e;
    e.nm = nm; e.en = en; e.d = d; e.st = st; e.cnt = exp_cnt;
    q.push_back(e);
    n_push++;
    @(posedge clk);
    #1;
    if (st && rst_n && exp_cnt != {CNTW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic idle();
    ex_rs = '0; ex_rs_valid = '0; stg_rd = '0; stg_wen = '0; stg_rdy = '0; stg_data = '0;
    lop_issue = 0; lop_rd = '0; lop_done = 0; lop_done_rd = '0; flush = 0;
  endtask

  initial begin
    rst_n = 0;
    idle();
    lop_done = 1; lop_done_rd = 5'd3;
    #1;
    chk("reset", 2'b00, 64'h0, 1'b0);
    #3 rst_n = 1;
    idle();
    @(posedge clk); #1;

    // Youngest stage wins when both match and are ready
    ex_rs = {5'd0, 5'd5}; ex_rs_valid = 2'b01;
    stg_rd = {5'd5, 5'd5}; stg_wen = 2'b11; stg_rdy = 2'b11;
    stg_data = {32'h0000_1234, 32'hAAAA_0000};
    chk("youngest_wins", 2'b01, {32'h0, 32'hAAAA_0000}, 1'b0);

    // Youngest not ready: older ready match is ignored, stall
    stg_rdy = 2'b10;
    chk("youngest_not_rdy", 2'b00, 64'h0, 1'b1);

    // Load-use on source 1, then forward from WB
    idle();
    ex_rs = {5'd7, 5'd0}; ex_rs_valid = 2'b10;
    stg_rd = {5'd0, 5'd7}; stg_wen = 2'b01; stg_rdy = 2'b00;
    chk("load_use_stall", 2'b00, 64'h0, 1'b1);
    stg_rd = {5'd7, 5'd0}; stg_wen = 2'b10; stg_rdy = 2'b10; stg_data = {32'h55, 32'h0};
    chk("load_use_fwd", 2'b10, {32'h55, 32'h0}, 1'b0);

    // x0 never forwards
    idle();
    ex_rs = {5'd0, 5'd0}; ex_rs_valid = 2'b11;
    stg_rd = {5'd0, 5'd0}; stg_wen = 2'b11; stg_rdy = 2'b11; stg_data = {32'hFFFF, 32'hEEEE};
    chk("x0_no_fwd", 2'b00, 64'h0, 1'b0);

    // Two sources from different stages
    ex_rs = {5'd4, 5'd3}; ex_rs_valid = 2'b11;
    stg_rd = {5'd3, 5'd4}; stg_data = {32'h33, 32'h44};
    chk("two_src", 2'b11, {32'h44, 32'h33}, 1'b0);

    // Match without ex_rs_valid does nothing
    ex_rs_valid = 2'b00;
    chk("src_not_valid", 2'b00, 64'h0, 1'b0);

    // Long op to x9, later read stalls until done
    idle();
    lop_issue = 1; lop_rd = 5'd9;
    chk("lop_issue9", 2'b00, 64'h0, 1'b0);
    idle();
    for (int k = 0; k < 3; k++) chk("lop_gap", 2'b00, 64'h0, 1'b0);
    ex_rs = {5'd0, 5'd9}; ex_rs_valid = 2'b01;
    chk("sb_stall_a", 2'b00, 64'h0, 1'b1);
    chk("sb_stall_b", 2'b00, 64'h0, 1'b1);
    // Ready stage match overrides pending
    stg_rd = {5'd9, 5'd0}; stg_wen = 2'b10; stg_rdy = 2'b10; stg_data = {32'h99, 32'h0};
    chk("rdy_over_pending", 2'b01, {32'h0, 32'h99}, 1'b0);
    stg_wen = 2'b00;
    // Second long op while one is pending: stalls and must not set its bit
    lop_issue = 1; lop_rd = 5'd10;
    chk("second_lop", 2'b00, 64'h0, 1'b1);
    lop_issue = 0;
    lop_done = 1; lop_done_rd = 5'd9;
    chk("done_cycle", 2'b00, 64'h0, 1'b1);
    lop_done = 0;
    chk("after_done", 2'b00, 64'h0, 1'b0);
    ex_rs = {5'd0, 5'd10};
    chk("gated_issue10", 2'b00, 64'h0, 1'b0);

    // Flush clears pending; simultaneous issue/done on the same reg leaves it set
    idle();
    lop_issue = 1; lop_rd = 5'd9;
    chk("reissue9", 2'b00, 64'h0, 1'b0);
    idle();
    flush = 1;
    chk("flush", 2'b00, 64'h0, 1'b0);
    flush = 0;
    ex_rs = {5'd0, 5'd9}; ex_rs_valid = 2'b01;
    chk("flushed9", 2'b00, 64'h0, 1'b0);
    idle();
    lop_issue = 1; lop_rd = 5'd4; lop_done = 1; lop_done_rd = 5'd4;
    chk("issue_done4", 2'b00, 64'h0, 1'b0);
    idle();
    ex_rs = {5'd4, 5'd0}; ex_rs_valid = 2'b10;
    chk("pending4", 2'b00, 64'h0, 1'b1);
    ex_rs_valid = 2'b00; lop_done = 1; lop_done_rd = 5'd4;
    chk("done4", 2'b00, 64'h0, 1'b0);
    lop_done = 0; ex_rs_valid = 2'b10;
    chk("cleared4", 2'b00, 64'h0, 1'b0);

    // Saturation then async reset mid-stall
    idle();
    ex_rs = {5'd0, 5'd7}; ex_rs_valid = 2'b01;
    stg_rd = {5'd0, 5'd7}; stg_wen = 2'b01; stg_rdy = 2'b00;
    for (int k = 0; k < (1 << CNTW) + 3; k++) chk("long_stall", 2'b00, 64'h0, 1'b1);
    if (exp_cnt != {CNTW{1'b1}}) begin
      n_bad++;
      $display("FAIL sat_model: got %0d, want %0d", exp_cnt, {CNTW{1'b1}});
    end
    chk("saturated", 2'b00, 64'h0, 1'b1);
    #2 rst_n = 0;
    exp_cnt = '0;
    chk("async_rst", 2'b00, 64'h0, 1'b1);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0 || n_cmp != n_push) begin
      n_bad++;
      $display("FAIL drain: got %0d compared, want %0d", n_cmp, n_push);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width.
REQ-002 SHALL have parameter NSRC, default 2, meaning number of EX-stage source operands.
REQ-003 SHALL have parameter NSTAGE, default 2, meaning number of forwarding stages; index 0 is youngest (MEM), NSTAGE-1 oldest (WB).
REQ-004 SHALL have parameter CNTW, default 16, meaning stall-counter width.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port ex_rs, input, NSRC*5, meaning EX source register indices, source i at bits [5i+4:5i].
REQ-008 SHALL have port ex_rs_valid, input, NSRC, meaning source i is actually read.
REQ-009 SHALL have port stg_rd, input, NSTAGE*5, meaning destination index per stage.
REQ-010 SHALL have port stg_wen, input, NSTAGE, meaning stage holds a register-writing instruction.
REQ-011 SHALL have port stg_rdy, input, NSTAGE, meaning the stage result is available this cycle (0 for a load still in MEM).
REQ-012 SHALL have port stg_data, input, NSTAGE*XLEN, meaning stage result, already muxed per RegSrc.
REQ-013 SHALL have port lop_issue, input, 1, and lop_rd, input, 5, meaning a long-latency op (div/rem) leaves EX targeting lop_rd.
REQ-014 SHALL have port lop_done, input, 1, and lop_done_rd, input, 5, meaning a long-latency op writes back lop_done_rd this cycle.
REQ-015 SHALL have port flush, input, 1, meaning pipeline flush.
REQ-016 SHALL have port fwd_en, output, NSRC, meaning source i takes forwarded data.
REQ-017 SHALL have port fwd_data, output, NSRC*XLEN, meaning forwarded operand per source.
REQ-018 SHALL have port stall, output, 1, meaning hold IF/ID/EX and bubble MEM.
REQ-019 SHALL have port stall_cnt, output, CNTW, meaning saturating count of stalled cycles.

Function
REQ-020 SHALL compute, per source i, a match on stage s when ex_rs_valid[i], stg_wen[s], ex_rs[i]==stg_rd[s] and ex_rs[i]!=0.
REQ-021 SHALL select the lowest-index matching stage only (youngest wins); older matches are ignored even if the youngest is not ready.
REQ-022 SHALL drive fwd_en[i]=1 and fwd_data[i]=stg_data of the selected stage when that stage has stg_rdy=1, combinationally in the same cycle.
REQ-023 SHALL drive fwd_en[i]=0 and fwd_data[i]=0 when no stage matches; no output is left unassigned in any path.
REQ-024 SHALL raise a data hazard for source i when the selected stage has stg_rdy=0.
REQ-025 SHALL hold a 32-bit pending vector; bit r is set on the edge where lop_issue=1 and lop_rd=r!=0, cleared on the edge where lop_done=1 and lop_done_rd=r; bit 0 is always 0.
REQ-026 SHALL, when set and clear hit the same bit in the same cycle, leave it set (new issue wins).
REQ-027 SHALL raise a scoreboard hazard for source i when ex_rs_valid[i], pending[ex_rs[i]]=1 and no stage match; a ready stage match overrides pending.
REQ-028 SHALL raise a scoreboard hazard when lop_issue=1 while any pending bit is set (one long op in flight).
REQ-029 SHALL drive stall as the OR of all data and scoreboard hazards, combinationally.
REQ-030 SHALL increment stall_cnt by 1 each cycle stall=1, saturating at all-ones.
REQ-031 SHALL, on flush, clear all pending bits on the next edge unless lop_done matches (done clears anyway); flush has no effect on stall_cnt.
REQ-032 SHALL gate lop_issue with stall: no pending bit is set in a cycle where stall=1.

Reset
REQ-033 SHALL, while rst_n=0, asynchronously clear pending and stall_cnt to 0; fwd_en, fwd_data and stall then follow inputs combinationally.
REQ-034 SHALL resume normal updates on the first rising clk after rst_n deasserts; a lop_done during reset is discarded.

Verification
REQ-035 SHALL pass: ex_rs[0]=5 valid, stage0 rd=5 rdy data=0xAAAA_0000, stage1 rd=5 rdy data=0x1234 -> fwd_en[0]=1, fwd_data[0]=0xAAAA_0000, stall=0.
REQ-036 SHALL pass: stage0 rd=7 wen rdy=0 (load), ex_rs[1]=7 -> stall=1, stall_cnt increments 0->1; next cycle stage1 rd=7 rdy data=0x55 -> fwd_data[1]=0x55, stall=0.
REQ-037 SHALL pass: ex_rs[0]=0, stage0 rd=0 wen rdy -> fwd_en[0]=0, fwd_data[0]=0, stall=0.
REQ-038 SHALL pass: lop_issue rd=9; 3 cycles later ex_rs[0]=9 no stage match -> stall=1 until lop_done rd=9, then pending[9]=0 and stall=0 next cycle.
REQ-039 SHALL pass: pending[9]=1, flush -> pending cleared next edge; same-cycle lop_issue rd=4 and lop_done rd=4 -> pending[4]=1.
REQ-040 SHALL pass: stall held 2^CNTW+3 cycles -> stall_cnt=all-ones; rst_n pulsed low mid-stall -> stall_cnt=0 immediately without a clock edge.
